mem_responder: RTL and testbench

Single-port data/instruction memory responder for the multicycle accumulator CPU. It services the controller's `MemRead`/`MemWrite` strobes with a programmable wait-state latency and a fully interlocked `ready` handshake. It also provides a side port for preloading program images while the memory is idle. It sits between the datapath's address/write-data mux outputs and the IR/MDR load inputs.

---
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Single-port instruction/data memory for the multicycle accumulator CPU.
//   Services MemRead/MemWrite strobes after WAIT_CYCLES wait states with a
//   one-cycle registered ready pulse, then interlocks until the controller
//   drops its strobes so a held request is never serviced twice. A side
//   port preloads program images while the memory is idle.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   MemRead    read request, held until ready is seen
//   MemWrite   write request, held until ready is seen
//   addr       request address, captured at acceptance
//   wdata      write data, captured at acceptance
//   load_en    preload strobe (honoured only when idle with no request)
//   load_addr  preload address
//   load_data  preload data
//   rdata      registered read data, held until the next read completes
//   ready      one-cycle response strobe
//   busy       high whenever a request is in flight or still held
//   err        one-cycle protocol-violation pulse
module mem_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;

  logic              rd_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic              accept;
  logic              enter_resp;
  logic              svc_rd;
  logic [ADDR_W-1:0] svc_addr;
  logic [DATA_W-1:0] svc_wdata;
  logic              svc_we;
  logic              preload_we;
  logic              err_nxt;

  assign req    = MemRead | MemWrite;
  assign accept = (state == IDLE) && req;
  assign busy   = (state != IDLE);

  // With zero wait states the request goes from IDLE straight into RESP on
  // the acceptance edge, so the service operands come from the live inputs
  // instead of the captured copies.
  assign svc_rd    = (state == IDLE) ? MemRead : rd_p0;
  assign svc_addr  = (state == IDLE) ? addr    : addr_p0;
  assign svc_wdata = (state == IDLE) ? wdata   : wdata_p0;

  assign enter_resp = (state_nxt == RESP);
  assign svc_we     = enter_resp && !svc_rd;
  assign preload_we = (state == IDLE) && !req && load_en;

  // An accepted request always wins over a simultaneous preload.
  assign err_nxt = (accept && MemRead && MemWrite) ||
                   (accept && load_en) ||
                   (busy && load_en);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
          cnt_nxt   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = req ? HOLD : IDLE;
      HOLD:    state_nxt = req ? HOLD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture stage: operands are frozen at acceptance, later input
  // changes (including a change of op) are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_p0    <= MemRead;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  // Storage: the service write commits on the edge entering RESP, so a read
  // issued afterwards to the same word observes the new data.
  always_ff @(posedge clk) begin
    if (svc_we)          mem[svc_addr]  <= svc_wdata;
    else if (preload_we) mem[load_addr] <= load_data;
  end

  // Control and response stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= enter_resp;
      err   <= err_nxt;
      if (enter_resp && svc_rd) rdata <= mem[svc_addr];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic       clk;
  logic       rst;
  logic       mr  [2];
  logic       mw  [2];
  logic       le  [2];
  logic [4:0] ad  [2];
  logic [4:0] la  [2];
  logic [7:0] wd  [2];
  logic [7:0] ldd [2];
  logic [7:0] rdo [2];
  logic       rdy [2];
  logic       bsy [2];
  logic       er  [2];

  int checks;
  int failures;
  bit chk_en;

  // Transaction-level reference model, one per unit.
  int         cyc;
  bit         m_busy  [2];
  int         m_resp  [2];
  bit         m_rd    [2];
  logic [4:0] m_addr  [2];
  logic [7:0] m_wd    [2];
  logic [7:0] m_rdata [2];
  bit         m_rdy   [2];
  bit         m_err   [2];
  logic [7:0] m_mem   [2][32];

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .addr(ad[0]),
    .wdata(wd[0]), .load_en(le[0]), .load_addr(la[0]), .load_data(ldd[0]),
    .rdata(rdo[0]), .ready(rdy[0]), .busy(bsy[0]), .err(er[0])
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .addr(ad[1]),
    .wdata(wd[1]), .load_en(le[1]), .load_addr(la[1]), .load_data(ldd[1]),
    .rdata(rdo[1]), .ready(rdy[1]), .busy(bsy[1]), .err(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s unit%0d got=%0h want=%0h t=%0t", nm, u, act, exp, $time);
    end
  endtask

  // Wait-state count per unit: unit 0 has 2, unit 1 has 0.
  function automatic int wc_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_busy[u] = 0; m_rdy[u] = 0; m_err[u] = 0; m_rdata[u] = 8'h00;
      end
      return;
    end
    cyc++;
    for (int u = 0; u < 2; u++) begin
      bit e;
      bit r;
      e = 0;
      r = 0;
      if (!m_busy[u]) begin
        if (mr[u] || mw[u]) begin
          e         = (mr[u] && mw[u]) || le[u];
          m_rd[u]   = mr[u];
          m_addr[u] = ad[u];
          m_wd[u]   = wd[u];
          m_busy[u] = 1;
          m_resp[u] = cyc + wc_of(u);
        end else if (le[u]) begin
          m_mem[u][la[u]] = ldd[u];
        end
      end else begin
        if (le[u]) e = 1;
        if (cyc > m_resp[u] && !mr[u] && !mw[u]) m_busy[u] = 0;
      end
      if (m_busy[u] && cyc == m_resp[u]) begin
        if (m_rd[u]) m_rdata[u] = m_mem[u][m_addr[u]];
        else         m_mem[u][m_addr[u]] = m_wd[u];
        r = 1;
      end
      m_rdy[u] = r;
      m_err[u] = e;
    end
  endtask

  task automatic preload(input int u, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    le[u] = 1'b1; la[u] = a; ldd[u] = d;
    @(negedge clk);
    le[u] = 1'b0;
  endtask

  // One request on unit u. ld_at >= 0 pulses load_en at that loop iteration
  // (0 = together with the request). Counts busy/err samples and any extra
  // ready seen during the hold phase.
  task automatic xact(input int u, input bit rd, input bit wr, input logic [4:0] a,
                      input logic [7:0] d, input int hold, input int ld_at,
                      input logic [4:0] lda, input logic [7:0] ldv,
                      output int lat, output int bc, output int ec, output int xr,
                      output logic [7:0] rv);
    bit ok;
    ok = 0; lat = 0; bc = 0; ec = 0; xr = 0; rv = 8'h00;
    @(negedge clk);
    mr[u] = rd; mw[u] = wr; ad[u] = a; wd[u] = d;
    for (int i = 0; i < 40; i++) begin
      if (i == ld_at) begin
        le[u] = 1'b1; la[u] = lda; ldd[u] = ldv;
      end
      @(negedge clk);
      le[u] = 1'b0;
      lat++;
      if (bsy[u]) bc++;
      if (er[u])  ec++;
      if (rdy[u]) begin
        ok = 1; rv = rdo[u];
        break;
      end
    end
    chk("ready_seen", u, 32'(ok), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bsy[u]) bc++;
      if (er[u])  ec++;
      if (rdy[u]) xr++;
    end
    mr[u] = 1'b0; mw[u] = 1'b0;
  endtask

  initial begin
    int lat, bc, ec, xr;
    logic [7:0] rv;
    checks = 0; failures = 0; chk_en = 0; cyc = 0;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      mr[u] = 0; mw[u] = 0; le[u] = 0; ad[u] = '0; la[u] = '0; wd[u] = '0; ldd[u] = '0;
      m_busy[u] = 0; m_resp[u] = 0; m_rd[u] = 0; m_addr[u] = '0; m_wd[u] = '0;
      m_rdata[u] = '0; m_rdy[u] = 0; m_err[u] = 0;
      for (int a = 0; a < 32; a++) m_mem[u][a] = 8'h00;
    end

    fork
      forever begin
        @(posedge clk or posedge rst);
        model_step();
      end
      forever begin
        @(negedge clk);
        if (chk_en) begin
          for (int u = 0; u < 2; u++) begin
            chk("ready", u, 32'(rdy[u]), 32'(m_rdy[u]));
            chk("busy",  u, 32'(bsy[u]), 32'(m_busy[u]));
            chk("err",   u, 32'(er[u]),  32'(m_err[u]));
            chk("rdata", u, 32'(rdo[u]), 32'(m_rdata[u]));
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_rdata", u, 32'(rdo[u]), 32'h00);
      chk("rst_ready", u, 32'(rdy[u]), 32'h0);
      chk("rst_busy",  u, 32'(bsy[u]), 32'h0);
      chk("rst_err",   u, 32'(er[u]),  32'h0);
    end
    chk_en = 1;
    @(negedge clk);
    rst = 1'b0;

    // Program image.
    for (int a = 0; a < 32; a++) begin
      logic [7:0] v;
      v = 8'($urandom);
      case (a)
        3:  v = 8'hA5;
        5:  v = 8'h5A;
        9:  v = 8'h11;
        12: v = 8'hC3;
        default: ;
      endcase
      preload(0, 5'(a), v);
    end
    for (int a = 0; a < 32; a++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (a == 0)  v = 8'h00;
      if (a == 31) v = 8'h9E;
      preload(1, 5'(a), v);
    end

    // Basic read with two wait states.
    xact(0, 1, 0, 5'd3, 8'h00, 0, -1, 5'd0, 8'h00, lat, bc, ec, xr, rv);
    chk("rd3_latency", 0, 32'(lat), 32'd3);
    chk("rd3_busy_cycles", 0, 32'(bc), 32'd3);
    chk("rd3_data", 0, 32'(rv), 32'hA5);
    chk("rd3_err", 0, 32'(ec), 32'd0);
    chk("model_rd3", 0, 32'(m_rdata[0]), 32'hA5);

    // Write then read back, read strobe held after ready.
    xact(0, 0, 1, 5'd7, 8'h3C, 0, -1, 5'd0, 8'h00, lat, bc, ec, xr, rv);
    chk("model_mem7", 0, 32'(m_mem[0][7]), 32'h3C);
    xact(0, 1, 0, 5'd7, 8'h00, 3, -1, 5'd0, 8'h00, lat, bc, ec, xr, rv);
    chk("raw7_data", 0, 32'(rv), 32'h3C);
    chk("hold_no_second_ready", 0, 32'(xr), 32'd0);
    chk("hold_busy_cycles", 0, 32'(bc), 32'd6);

    // Zero wait states.
    xact(1, 1, 0, 5'd0, 8'h00, 0, -1, 5'd0, 8'h00, lat, bc, ec, xr, rv);
    chk("w0_rd0_latency", 1, 32'(lat), 32'd1);
    chk("w0_rd0_data", 1, 32'(rv), 32'h00);
    xact(1, 1, 0, 5'd31, 8'h00, 0, -1, 5'd0, 8'h00, lat, bc, ec, xr, rv);
    chk("w0_rd31_latency", 1, 32'(lat), 32'd1);
    chk("w0_rd31_data", 1, 32'(rv), 32'h9E);

    // Both strobes: read wins, err once, word untouched.
    xact(0, 1, 1, 5'd5, 8'hFF, 0, -1, 5'd0, 8'h00, lat, bc, ec, xr, rv);
    chk("both_err_pulses", 0, 32'(ec), 32'd1);
    chk("both_read_data", 0, 32'(rv), 32'h5A);
    xact(0, 1, 0, 5'd5, 8'h00, 0, -1, 5'd0, 8'h00, lat, bc, ec, xr, rv);
    chk("both_mem5_kept", 0, 32'(rv), 32'h5A);

    // Preload attempt during WAIT is dropped and flagged.
    xact(0, 1, 0, 5'd12, 8'h00, 0, 1, 5'd12, 8'hEE, lat, bc, ec, xr, rv);
    chk("busy_load_err", 0, 32'(ec), 32'd1);
    chk("busy_load_rdata", 0, 32'(rv), 32'hC3);
    xact(0, 1, 0, 5'd12, 8'h00, 0, -1, 5'd0, 8'h00, lat, bc, ec, xr, rv);
    chk("busy_load_mem12_kept", 0, 32'(rv), 32'hC3);

    // Reset during the wait phase of a write.
    @(negedge clk);
    mw[0] = 1'b1; ad[0] = 5'd9; wd[0] = 8'h77;
    @(negedge clk);
    chk("pre_rst_busy", 0, 32'(bsy[0]), 32'd1);
    #1;
    rst = 1'b1; mw[0] = 1'b0;
    #1;
    chk("async_rst_ready", 0, 32'(rdy[0]), 32'd0);
    chk("async_rst_busy", 0, 32'(bsy[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xact(0, 1, 0, 5'd9, 8'h00, 0, -1, 5'd0, 8'h00, lat, bc, ec, xr, rv);
    chk("rst_write_discarded", 0, 32'(rv), 32'h11);
    chk("model_mem9", 0, 32'(m_mem[0][9]), 32'h11);

    // Randomized traffic on both units.
    for (int n = 0; n < 240; n++) begin
      int u, kind, hold, ld_at;
      bit rd, wr;
      u    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        preload(u, 5'($urandom), 8'($urandom));
      end else begin
        rd = (kind < 6);
        wr = !rd;
        if (kind == 9) begin rd = 1; wr = 1; end
        hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        ld_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
        xact(u, rd, wr, 5'($urandom), 8'($urandom), hold, ld_at,
             5'($urandom), 8'($urandom), lat, bc, ec, xr, rv);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
